// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte output holding register and a valid/ready consumer port.
// Samples each bit at its centre after a 2-flop synchronizer on the serial line.
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q, rx_s_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             byte_done;

    // Consumer handshake: a byte transfers on any rising edge where valid=1 and ready=1;
    // valid never drops without such a transfer, and data is frozen while valid=1 unless
    // a transfer and a new byte completion coincide on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        fe_d      = 1'b0;
        ov_d      = 1'b0;
        byte_done = 1'b0;
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is never missed.
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (rx_s_q) byte_done = 1'b1;
                    else        fe_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (byte_done) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ov_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: reset checks, a table of frame outcomes, hand-built corner sequences
// and a randomized frame stream checked against a transaction-level receiver model.
module tb_uart_rx;

    localparam int CPB = 104;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .framing_error(framing_error),
        .overrun      (overrun),
        .state_dbg    (state_dbg)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_t0 = 0;

    int fe_cnt = 0, ov_cnt = 0, rise_cnt = 0, rise_cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- clock / cycle counter ----------------
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- monitor (samples on the falling edge) ----------------
    initial begin
        logic       p_valid, p_ready, p_fe, p_ov;
        logic [7:0] p_data;
        p_valid = 1'b0; p_ready = 1'b0; p_fe = 1'b0; p_ov = 1'b0; p_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid && !p_valid) begin
                    rise_cnt++;
                    rise_cyc = cyc;
                end
                if (framing_error) begin
                    fe_cnt++;
                    check("fe_one_cycle", {31'd0, p_fe}, 32'd0);
                end
                if (overrun) begin
                    ov_cnt++;
                    check("ov_one_cycle", {31'd0, p_ov}, 32'd0);
                end
                if (p_valid && !p_ready && valid)
                    check("data_held", {24'd0, data}, {24'd0, p_data});
                if (valid && ready) got_q.push_back(data);
            end
            p_valid = valid; p_ready = ready; p_fe = framing_error; p_ov = overrun; p_data = data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Drives the first nbits of a start/data/stop frame, then returns the line to idle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits = 10);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            rx = f[i];
            if (i == 0) last_t0 = cyc;
            tick(CPB);
        end
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx = 1'b1;
        tick(4);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic       rdy;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         d_fe;
        int         d_ov;
    } vec_t;

    vec_t tbl[7];

    // ---------------- watchdog ----------------
    initial begin
        #(95_000 * 10);
        n_fail++;
        $display("FAIL watchdog: got timeout at cycle %0d expected end of test", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int fe0, ov0, rise0, lat, exact_seen;
        logic model_full;
        logic [7:0] model_buf;
        int exp_fe, exp_ov;

        tbl[0] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 0, 0};
        tbl[2] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 0, 1};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 8'h11, 1'b1, 1, 0};
        tbl[4] = '{8'h96, 1'b1, 1'b1, 8'h96, 1'b0, 0, 0};
        tbl[5] = '{8'hE7, 1'b1, 1'b0, 8'hE7, 1'b1, 0, 0};
        tbl[6] = '{8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0, 0, 0};

        ready = 1'b0;
        do_reset();
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_fe", {31'd0, framing_error}, 32'd0);
        check("rst_ov", {31'd0, overrun}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        tick(3);

        // Table: one frame per entry, outcome checked after the line settles.
        for (int i = 0; i < 7; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            ready = tbl[i].rdy;
            send_frame(tbl[i].b, tbl[i].stop);
            tick(60);
            check($sformatf("tbl%0d_data", i), {24'd0, data}, {24'd0, tbl[i].exp_data});
            check($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_fe", i), fe_cnt - fe0, tbl[i].d_fe);
            check($sformatf("tbl%0d_ov", i), ov_cnt - ov0, tbl[i].d_ov);
        end
        ready = 1'b0;

        // 0x55 with ready low: latency window, hold, then single-cycle accept.
        send_frame(8'h55, 1'b1);
        lat = rise_cyc - last_t0;
        check("latency_window", {31'd0, (lat >= 990 && lat <= 994)}, 32'd1);
        tick(200);
        check("hold55_data", {24'd0, data}, 32'h55);
        check("hold55_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("accept55_valid", {31'd0, valid}, 32'd0);

        // Back-to-back 0xFF, 0x00 with ready high.
        fe0 = fe_cnt; ov0 = ov_cnt;
        got_q.delete();
        ready = 1'b1;
        send_frame(8'hFF, 1'b1);
        send_frame(8'h00, 1'b1);
        tick(60);
        check("b2b_count", got_q.size(), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_first", {24'd0, got_q[0]}, 32'hFF);
            check("b2b_second", {24'd0, got_q[1]}, 32'h00);
        end
        check("b2b_fe", fe_cnt - fe0, 32'd0);
        check("b2b_ov", ov_cnt - ov0, 32'd0);
        ready = 1'b0;

        // Short low glitch is rejected, next frame is clean.
        fe0 = fe_cnt; rise0 = rise_cnt;
        rx = 1'b0;
        tick(20);
        rx = 1'b1;
        tick(100);
        check("glitch_no_valid", rise_cnt - rise0, 32'd0);
        check("glitch_no_fe", fe_cnt - fe0, 32'd0);
        check("glitch_idle", {30'd0, state_dbg}, 32'd0);
        send_frame(8'hA5, 1'b1);
        tick(60);
        check("after_glitch_data", {24'd0, data}, 32'hA5);
        check("after_glitch_valid", {31'd0, valid}, 32'd1);

        // Sweep a one-cycle ready pulse across the completion edge while a byte is held.
        exact_seen = 0;
        for (int off = -4; off <= 4; off++) begin
            logic [7:0] old_b, new_b;
            old_b = 8'h40 + 8'(off + 4);
            new_b = 8'h80 + 8'(off + 4);
            ready = 1'b1;
            tick(2);
            ready = 1'b0;
            send_frame(old_b, 1'b1);
            tick(10);
            ov0 = ov_cnt; rise0 = rise_cnt;
            fork
                send_frame(new_b, 1'b1);
                begin
                    tick(990 + off);
                    ready = 1'b1;
                    tick(1);
                    ready = 1'b0;
                end
            join
            tick(60);
            if (ov_cnt - ov0 == 1) begin
                check($sformatf("late%0d_valid", off), {31'd0, valid}, 32'd0);
                check($sformatf("late%0d_data", off), {24'd0, data}, {24'd0, old_b});
            end else begin
                check($sformatf("sweep%0d_ov", off), ov_cnt - ov0, 32'd0);
                check($sformatf("sweep%0d_valid", off), {31'd0, valid}, 32'd1);
                check($sformatf("sweep%0d_data", off), {24'd0, data}, {24'd0, new_b});
                if (rise_cnt == rise0) exact_seen++;
            end
        end
        check("same_edge_accept_seen", exact_seen, 32'd1);

        // Reset during data bit 4 of 0xC3 abandons the frame.
        ready = 1'b0;
        send_frame(8'hC3, 1'b1, 5);
        rx = 1'b0;
        tick(50);
        rst = 1'b1;
        rx = 1'b1;
        tick(3);
        check("midrst_data", {24'd0, data}, 32'h00);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_fe", {31'd0, framing_error}, 32'd0);
        check("midrst_ov", {31'd0, overrun}, 32'd0);
        check("midrst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt; rise0 = rise_cnt;
        tick(200);
        check("midrst_no_events", (fe_cnt - fe0) + (ov_cnt - ov0) + (rise_cnt - rise0), 32'd0);
        send_frame(8'h01, 1'b1);
        tick(60);
        check("post_rst_data", {24'd0, data}, 32'h01);
        check("post_rst_valid", {31'd0, valid}, 32'd1);

        // Randomized frame stream against a transaction-level model.
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
        got_q.delete();
        exp_q.delete();
        model_full = 1'b0;
        model_buf = 8'h00;
        exp_fe = 0; exp_ov = 0;
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            logic stop, r;
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            r    = 1'($urandom_range(0, 1));
            if (r && model_full) begin
                exp_q.push_back(model_buf);
                model_full = 1'b0;
            end
            if (!stop) exp_fe++;
            else if (model_full) exp_ov++;
            else if (r) exp_q.push_back(b);
            else begin
                model_full = 1'b1;
                model_buf = b;
            end
            ready = r;
            send_frame(b, stop);
            if (!stop) tick(60);
            else tick($urandom_range(0, 20));
        end
        ready = 1'b1;
        if (model_full) exp_q.push_back(model_buf);
        tick(8);
        ready = 1'b0;
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_byte%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check("rand_fe", fe_cnt - fe0, exp_fe);
        check("rand_ov", ov_cnt - ov0, exp_ov);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
